// File: rtl/perf_cntr_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_cntr_bank
// Description : Bank of NUM_CNTRS performance counters on the data bus perf
//               window. Each channel runs in clear / run / hold / event mode,
//               keeps a sticky overflow flag (write-1-to-clear) and can be
//               driven together through a global control register. Read data
//               is registered (1-cycle latency).
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i    in   1           system clock
//   rst_i    in   1           synchronous active-high reset
//   addr_i   in   ADDR_WIDTH  byte address (read and write)
//   wdata_i  in   32          write data
//   w_en_i   in   1           write strobe (already window-qualified)
//   event_i  in   NUM_CNTRS   per-channel event pulses
//   rdata_o  out  32          registered read data
//
// Register map (ch = addr[ADDR_WIDTH-1:4], reg = addr[3:2])
//   ch < NUM_CNTRS : 0 CTRL, 1 HI, 2 LO, 3 STATUS
//   ch == NUM_CNTRS: 0 GCTRL (WO), 1 SNAP (WO), 2 ID (RO), 3 reads 0
//
// Build option
//   PERF_SNAPSHOT_EN : adds per-channel shadow registers loaded by a SNAP
//                      write; HI/LO then read the shadow instead of the live
//                      counter, and ID bit 31 reads 1.
// ============================================================================
module perf_cntr_bank #(
  parameter int NUM_CNTRS  = 4,
  parameter int CNTR_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  w_en_i,
  input  logic [NUM_CNTRS-1:0]  event_i,
  output logic [31:0]           rdata_o
);

  localparam int CH_W = ADDR_WIDTH - 4;

  localparam logic [1:0] c_mode_clear = 2'd0;
  localparam logic [1:0] c_mode_run   = 2'd1;
  localparam logic [1:0] c_mode_event = 2'd3;

  localparam logic [1:0] c_reg_ctrl   = 2'd0;
  localparam logic [1:0] c_reg_hi     = 2'd1;
  localparam logic [1:0] c_reg_lo     = 2'd2;
  localparam logic [1:0] c_reg_status = 2'd3;
  localparam logic [1:0] c_reg_gctrl  = 2'd0;
  localparam logic [1:0] c_reg_snap   = 2'd1;
  localparam logic [1:0] c_reg_id     = 2'd2;

  localparam logic [CNTR_WIDTH-1:0] c_cntr_one = CNTR_WIDTH'(1);

`ifdef PERF_SNAPSHOT_EN
  localparam logic c_snap_present = 1'b1;
`else
  localparam logic c_snap_present = 1'b0;
`endif

  localparam logic [31:0] c_id_word = {c_snap_present, 15'd0,
                                       8'(CNTR_WIDTH), 8'(NUM_CNTRS)};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]            r_mode [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0] r_cntr [NUM_CNTRS];
  logic [NUM_CNTRS-1:0]  r_ovf;
  logic [31:0]           r_rdata;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [CH_W-1:0]      w_ch;
  logic [1:0]           w_reg;
  logic                 w_glb_sel;
  logic                 w_gctrl_wr;
  logic                 w_snap_wr;
  logic [NUM_CNTRS-1:0] w_ch_sel;
  logic [NUM_CNTRS-1:0] w_ctrl_wr;
  logic [NUM_CNTRS-1:0] w_ovf_clr;
  logic [NUM_CNTRS-1:0] w_inc;
  logic [NUM_CNTRS-1:0] w_wrap;

  assign w_ch       = addr_i[ADDR_WIDTH-1:4];
  assign w_reg      = addr_i[3:2];
  assign w_glb_sel  = (w_ch == CH_W'(NUM_CNTRS));
  assign w_gctrl_wr = w_en_i & w_glb_sel & (w_reg == c_reg_gctrl);
  assign w_snap_wr  = w_en_i & w_glb_sel & (w_reg == c_reg_snap);

  always_comb begin
    w_ch_sel  = '0;
    w_ctrl_wr = '0;
    w_ovf_clr = '0;
    w_inc     = '0;
    w_wrap    = '0;
    for (int n = 0; n < NUM_CNTRS; n++) begin
      w_ch_sel[n]  = (w_ch == CH_W'(n));
      w_ctrl_wr[n] = w_en_i & w_ch_sel[n] & (w_reg == c_reg_ctrl);
      w_ovf_clr[n] = w_en_i & w_ch_sel[n] & (w_reg == c_reg_status) & wdata_i[0];
      w_inc[n]     = (r_mode[n] == c_mode_run) |
                     ((r_mode[n] == c_mode_event) & event_i[n]);
      // Incrementing from all-ones is the only way to wrap
      w_wrap[n]    = w_inc[n] & (&r_cntr[n]);
    end
  end

  // --------------------------------------------------------------------------
  // Modes, counters and overflow flags
  // The counter acts on r_mode as registered, so a CTRL write only changes
  // counting behaviour from the cycle after the write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_CNTRS; n++) begin
        r_mode[n] <= '0;
        r_cntr[n] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int n = 0; n < NUM_CNTRS; n++) begin
        if (w_ctrl_wr[n] || w_gctrl_wr) begin
          r_mode[n] <= wdata_i[1:0];
        end

        if (r_mode[n] == c_mode_clear) begin
          r_cntr[n] <= '0;
        end else if (w_inc[n]) begin
          r_cntr[n] <= r_cntr[n] + c_cntr_one;
        end

        // A wrap in the same cycle as a W1C keeps the flag set
        if (w_wrap[n]) begin
          r_ovf[n] <= 1'b1;
        end else if (w_ovf_clr[n]) begin
          r_ovf[n] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counter view for HI/LO reads, zero-extended to 64 bits
  // --------------------------------------------------------------------------
  logic [63:0] w_view [NUM_CNTRS];

`ifdef PERF_SNAPSHOT_EN
  logic [CNTR_WIDTH-1:0] r_shadow [NUM_CNTRS];

  // Captures the pre-increment counter value of the SNAP write edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_CNTRS; n++) begin
        r_shadow[n] <= '0;
      end
    end else if (w_snap_wr) begin
      for (int n = 0; n < NUM_CNTRS; n++) begin
        r_shadow[n] <= r_cntr[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CNTRS; n++) begin
      w_view[n] = 64'(r_shadow[n]);
    end
  end
`else
  always_comb begin
    for (int n = 0; n < NUM_CNTRS; n++) begin
      w_view[n] = 64'(r_cntr[n]);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read mux (values before this edge's updates) and read register
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < NUM_CNTRS; n++) begin
      if (w_ch_sel[n]) begin
        case (w_reg)
          c_reg_ctrl: w_rdata = {30'd0, r_mode[n]};
          c_reg_hi:   w_rdata = w_view[n][63:32];
          c_reg_lo:   w_rdata = w_view[n][31:0];
          default:    w_rdata = {31'd0, r_ovf[n]};
        endcase
      end
    end
    if (w_glb_sel && (w_reg == c_reg_id)) begin
      w_rdata = c_id_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign rdata_o = r_rdata;

  // Bits that carry no function in this block
  logic w_unused;
  assign w_unused = &{1'b0, addr_i[1:0], wdata_i[31:2], w_snap_wr};

endmodule
`default_nettype wire
